// File: rtl/tcam_bram_if.sv
// tcam_bram_if: update-port and compare/match
// signal bundle for the BRAM-sliced TCAM.
interface tcam_bram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  localparam int N = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] write_mask;
  logic                  write_delete;
  logic                  write_enable;
  logic                  write_busy;

  logic [DATA_WIDTH-1:0] compare_data;
  logic                  compare_valid;

  logic                  match_valid;
  logic [N-1:0]          match_many;
  logic [N-1:0]          match_single;
  logic [ADDR_WIDTH-1:0] match_addr;
  logic                  match;

  modport master (
    output write_addr, write_data, write_mask,
    output write_delete, write_enable,
    output compare_data, compare_valid,
    input  write_busy, match_valid, match_many,
    input  match_single, match_addr, match
  );

  modport slave (
    input  write_addr, write_data, write_mask,
    input  write_delete, write_enable,
    input  compare_data, compare_valid,
    output write_busy, match_valid, match_many,
    output match_single, match_addr, match
  );
endinterface

// File: rtl/tcam_bram.sv
// tcam_bram: ternary CAM built from per-slice
// N-bit-wide RAMs indexed by key-slice value.
module tcam_bram #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 9
) (
  input logic        clk,
  input logic        rst,
  tcam_bram_if.slave bus
);
  localparam int N = 2 ** ADDR_WIDTH;
  localparam int S =
    (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

  typedef enum logic [1:0] {
    INIT, IDLE, RD, WR
  } state_t;

  state_t                 state_q, state_d;
  logic [SLICE_WIDTH-1:0] k_q, k_d;
  logic                   busy_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  mask_q, mask_d;
  logic                   del_q, del_d;
  logic [N-1:0]           col;

  logic [N-1:0]           slice_hit [S];
  logic [N-1:0]           hits;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [N-1:0]           win_single;

  logic                   cmp_v_q;
  logic                   mv_q;
  logic                   m_q;
  logic [N-1:0]           many_q;
  logic [N-1:0]           single_q;
  logic [ADDR_WIDTH-1:0]  maddr_q;

  assign col = N'(1) << addr_q;

  // Updater next state: clear sweep, then per-key RMW sweeps.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    del_d   = del_q;
    unique case (state_q)
      INIT: begin
        k_d = k_q + 1'b1;
        if (k_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.write_enable) begin
          state_d = RD;
          k_d     = '0;
          addr_d  = bus.write_addr;
          data_d  = bus.write_data;
          mask_d  = bus.write_mask;
          del_d   = bus.write_delete;
        end
      end
      RD: state_d = WR;
      WR: begin
        k_d = k_q + 1'b1;
        state_d = (k_q == '1) ? IDLE : RD;
      end
      default: state_d = INIT;
    endcase
  end

  // Updater state, sweep counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      k_q     <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Latched update request.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
    del_q  <= del_d;
  end

  for (genvar s = 0; s < S; s++) begin : g_slice
    localparam int LO = s * SLICE_WIDTH;
    localparam int W =
      (DATA_WIDTH - LO < SLICE_WIDTH) ?
      DATA_WIDTH - LO : SLICE_WIDTH;

    logic [N-1:0] mem [2**W];
    logic [W-1:0] a_addr;
    logic [W-1:0] b_addr;
    logic [N-1:0] rd_a_q;
    logic [N-1:0] rd_b_q;
    logic [N-1:0] wdata;
    logic         we;
    logic         set;

    assign a_addr = bus.compare_data[LO +: W];
    assign b_addr = k_q[W-1:0];
    assign set = !del_q &&
      (((b_addr ^ data_q[LO +: W]) &
        mask_q[LO +: W]) == '0);
    assign we = (state_q == INIT) ||
                (state_q == WR);
    assign wdata = (state_q == INIT) ? '0 :
      ((rd_b_q & ~col) | (set ? col : '0));

    // Port B read-modify-write, port A compare read.
    always_ff @(posedge clk) begin
      if (we) mem[b_addr] <= wdata;
      rd_b_q <= mem[b_addr];
      rd_a_q <= mem[a_addr];
    end

    assign slice_hit[s] = rd_a_q;
  end

  // Raw hit vector: AND across all slices.
  always_comb begin
    hits = '1;
    for (int s = 0; s < S; s++) begin
      hits &= slice_hit[s];
    end
  end

  // Lowest-index hit wins.
  always_comb begin
    win_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hits[i]) win_addr = ADDR_WIDTH'(i);
    end
    win_single = (|hits) ?
      (N'(1) << win_addr) : '0;
  end

  // Compare pipeline; results hold between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_v_q  <= 1'b0;
      mv_q     <= 1'b0;
      m_q      <= 1'b0;
      many_q   <= '0;
      single_q <= '0;
      maddr_q  <= '0;
    end else begin
      cmp_v_q <= bus.compare_valid;
      mv_q    <= cmp_v_q;
      if (cmp_v_q) begin
        m_q      <= |hits;
        many_q   <= hits;
        single_q <= win_single;
        maddr_q  <= win_addr;
      end
    end
  end

  assign bus.write_busy   = busy_q;
  assign bus.match_valid  = mv_q;
  assign bus.match        = m_q;
  assign bus.match_many   = many_q;
  assign bus.match_single = single_q;
  assign bus.match_addr   = maddr_q;
endmodule

// File: tb/tb_tcam_bram.sv
// tb_tcam_bram: scoreboard bench for tcam_bram
// with 16-bit keys, 8 entries, 8-bit slices.
module tb_tcam_bram;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int SW = 8;
  localparam int N  = 8;
  localparam int RW = 1 + AW + 2 * N;

  typedef struct packed {
    logic          match;
    logic [AW-1:0] addr;
    logic [N-1:0]  many;
    logic [N-1:0]  single;
  } res_t;

  typedef struct packed {
    res_t          r;
    logic [RW-1:0] cm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int upd_idx = -1;

  logic [DW-1:0] m_data [N];
  logic [DW-1:0] m_mask [N];
  bit            m_val  [N];

  logic [DW-1:0] key_q [$];
  exp_t          exp_q [$];
  logic [RW-1:0] obs_q [$];

  tcam_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  tcam_bram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .SLICE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.match_valid === 1'b1)
      obs_q.push_back({bus.match, bus.match_addr,
                       bus.match_many, bus.match_single});
  end

  function automatic exp_t model(input logic [DW-1:0] key);
    exp_t e;
    res_t c;
    logic [N-1:0] many;
    many = '0;
    for (int i = 0; i < N; i++)
      if (m_val[i] && ((key ^ m_data[i]) & m_mask[i]) == '0)
        many[i] = 1'b1;
    e.r.many = many;
    e.r.match = |many;
    e.r.addr = '0;
    e.r.single = '0;
    for (int i = N - 1; i >= 0; i--)
      if (many[i]) e.r.addr = AW'(i);
    if (|many) e.r.single = N'(1) << e.r.addr;
    c = '1;
    if (upd_idx >= 0) begin
      c.many[upd_idx] = 1'b0;
      if ((many & ((N'(1) << upd_idx) - N'(1))) == '0) begin
        c.match = 1'b0;
        c.addr = '0;
        c.single = '0;
      end
    end
    e.cm = c;
    return e;
  endfunction

  task automatic run_cmp(input string name);
    int n;
    n = key_q.size();
    obs_q.delete();
    exp_q.delete();
    while (key_q.size() > 0) begin
      @(negedge clk);
      bus.compare_data = key_q.pop_front();
      bus.compare_valid = 1'b1;
      exp_q.push_back(model(bus.compare_data));
    end
    @(negedge clk);
    bus.compare_valid = 1'b0;
    for (int i = 0; i < 8 && obs_q.size() < n; i++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL %s pulses got %0d want %0d",
               name, obs_q.size(), n);
    end
  endtask

  task automatic start_write(input logic [AW-1:0] a,
                             input logic [DW-1:0] d,
                             input logic [DW-1:0] m,
                             input logic del);
    for (int i = 0; i < 3000 && bus.write_busy; i++)
      @(posedge clk);
    @(negedge clk);
    bus.write_addr = a;
    bus.write_data = d;
    bus.write_mask = m;
    bus.write_delete = del;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    t0 = cyc;
    m_val[a] = !del;
    m_data[a] = d;
    m_mask[a] = m;
  endtask

  task automatic wait_idle(output int el);
    while (bus.write_busy && cyc - t0 < 3000) begin
      @(posedge clk);
      #1;
    end
    el = cyc - t0;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (bus.write_busy && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    exp_t e;
    logic [RW-1:0] o;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.write_busy, bus.match_valid, bus.match,
         bus.match_many, bus.match_single, bus.match_addr}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL rst_state got busy=%b mv=%b m=%b many=%h",
               bus.write_busy, bus.match_valid, bus.match,
               bus.match_many);
    end
    rst = 1'b0;
    count_init(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL init_busy got %0d want 256", n);
    end
    key_q.push_back(16'h0000);
    key_q.push_back(16'hFFFF);
    run_cmp("empty");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL empty got %h want %h", o, e.r);
      end
    end
  endtask

  task automatic test_write_hit();
    int el;
    exp_t e;
    logic [RW-1:0] o;
    start_write(3'd2, 16'h12AB, 16'hFFFF, 1'b0);
    wait_idle(el);
    checks++;
    if (el != 512) begin
      errors++;
      $display("FAIL wr_busy got %0d want 512", el);
    end
    @(negedge clk);
    bus.compare_data = 16'h12AB;
    bus.compare_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.match_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_c1 got mv=%b want 0", bus.match_valid);
    end
    @(negedge clk);
    bus.compare_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.match_valid, bus.match, bus.match_addr,
         bus.match_single} !== {1'b1, 1'b1, 3'd2, 8'h04}) begin
      errors++;
      $display("FAIL lat_c2 got mv=%b m=%b a=%0d s=%h want 1 1 2 04",
               bus.match_valid, bus.match, bus.match_addr,
               bus.match_single);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.match_valid, bus.match_addr, bus.match_single}
        !== {1'b0, 3'd2, 8'h04}) begin
      errors++;
      $display("FAIL hold got mv=%b a=%0d s=%h want 0 2 04",
               bus.match_valid, bus.match_addr, bus.match_single);
    end
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h12AC);
    key_q.push_back(16'h92AB);
    key_q.push_back(16'h12AB);
    run_cmp("exact");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL exact got %h want %h", o, e.r);
      end
    end
  endtask

  task automatic test_mask();
    int el;
    exp_t e;
    logic [RW-1:0] o;
    start_write(3'd5, 16'h1200, 16'hFF00, 1'b0);
    wait_idle(el);
    start_write(3'd1, 16'h0000, 16'h0000, 1'b0);
    wait_idle(el);
    checks++;
    if (el != 512) begin
      errors++;
      $display("FAIL mask_busy got %0d want 512", el);
    end
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h1255);
    key_q.push_back(16'h3400);
    key_q.push_back(16'h12FF);
    run_cmp("mask");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL mask got %h want %h", o, e.r);
      end
    end
  endtask

  task automatic test_delete_overwrite();
    int el;
    exp_t e;
    logic [RW-1:0] o;
    start_write(3'd1, 16'h0000, 16'h0000, 1'b1);
    wait_idle(el);
    checks++;
    if (el != 512) begin
      errors++;
      $display("FAIL del_busy got %0d want 512", el);
    end
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h3400);
    run_cmp("delete");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL delete got %h want %h", o, e.r);
      end
    end
    start_write(3'd2, 16'h5555, 16'hFFFF, 1'b0);
    wait_idle(el);
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h5555);
    key_q.push_back(16'h55AB);
    run_cmp("overwrite");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL overwrite got %h want %h", o, e.r);
      end
    end
  endtask

  task automatic test_back_to_back();
    int el;
    exp_t e;
    logic [RW-1:0] o;
    start_write(3'd7, 16'h00AB, 16'h00FF, 1'b0);
    upd_idx = 7;
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h1200);
    key_q.push_back(16'h5555);
    key_q.push_back(16'h0000);
    key_q.push_back(16'h12FF);
    key_q.push_back(16'hFFFF);
    key_q.push_back(16'h34AB);
    key_q.push_back(16'h1255);
    run_cmp("b2b");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL b2b got %h want %h", o, e.r);
      end
    end
    checks++;
    if (bus.write_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1", bus.write_busy);
    end
    @(negedge clk);
    bus.write_addr = 3'd0;
    bus.write_data = 16'hFFFF;
    bus.write_mask = 16'h0000;
    bus.write_delete = 1'b0;
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    wait_idle(el);
    upd_idx = -1;
    checks++;
    if (el != 512) begin
      errors++;
      $display("FAIL b2b_len got %0d want 512", el);
    end
    key_q.push_back(16'h99AB);
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h5555);
    key_q.push_back(16'h0000);
    run_cmp("after_upd");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL after_upd got %h want %h", o, e.r);
      end
    end
  endtask

  task automatic test_rst_mid_update();
    int n;
    exp_t e;
    logic [RW-1:0] o;
    key_q.push_back(16'h99AB);
    run_cmp("pre_rst");
    obs_q.delete();
    exp_q.delete();
    start_write(3'd3, 16'hAAAA, 16'hFFFF, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.write_busy, bus.match_valid, bus.match,
         bus.match_many, bus.match_single, bus.match_addr}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL mid_rst got busy=%b mv=%b m=%b many=%h a=%0d",
               bus.write_busy, bus.match_valid, bus.match,
               bus.match_many, bus.match_addr);
    end
    rst = 1'b0;
    count_init(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL reinit_busy got %0d want 256", n);
    end
    for (int i = 0; i < N; i++) m_val[i] = 1'b0;
    key_q.push_back(16'hAAAA);
    key_q.push_back(16'h12AB);
    key_q.push_back(16'h5555);
    key_q.push_back(16'h99AB);
    key_q.push_back(16'h0000);
    key_q.push_back(16'h1200);
    run_cmp("post_rst");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o & e.cm) !== (e.r & e.cm)) begin
        errors++;
        $display("FAIL post_rst got %h want %h", o, e.r);
      end
    end
  endtask

  initial begin
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.write_mask = '0;
    bus.write_delete = 1'b0;
    bus.write_enable = 1'b0;
    bus.compare_data = '0;
    bus.compare_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = 1'b0;
      m_data[i] = '0;
      m_mask[i] = '0;
    end
    test_reset();
    test_write_hit();
    test_mask();
    test_delete_overwrite();
    test_back_to_back();
    test_rst_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
